// File: rtl/ccc_lock_supervisor.sv
// Power-up sequencer and lock supervisor for one fabric CCC/PLL instance.
// Pulses the PLL reset, qualifies LOCK, and releases a fabric reset once lock has been stable long enough.
module ccc_lock_supervisor #(
  parameter int ARST_CYCLES         = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 17
) (
  input  logic       PCLK,
  input  logic       PRESET_N,
  input  logic       LOCK,
  input  logic       ENABLE,
  output logic       PLL_POWERDOWN_N,
  output logic       PLL_ARST_N,
  output logic       FABRIC_RESET_N,
  output logic       LOCKED,
  output logic       FAULT,
  output logic [7:0] RELOCK_COUNT,
  output logic [2:0] STATE
);

  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_RESET_PLL = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABILIZE = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  state_t             state, state_next;
  logic               sync_ff, lock_s;
  logic [CNT_W-1:0]   timer, to_cnt;
  logic [RETRY_W-1:0] retry, retry_next;
  logic               timeout, relock_evt;
  logic               in_window, next_in_window;

  // The timeout window spans WAIT_LOCK and STABILIZE so that lock chatter cannot restart it.
  assign in_window      = (state == ST_WAIT_LOCK) || (state == ST_STABILIZE);
  assign next_in_window = (state_next == ST_WAIT_LOCK) || (state_next == ST_STABILIZE);
  assign timeout        = (to_cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_next = state;
    retry_next = retry;
    relock_evt = 1'b0;
    if (state == ST_OFF) retry_next = '0;

    if (!ENABLE) begin
      state_next = ST_OFF;
    end else begin
      case (state)
        ST_OFF:       state_next = ST_RESET_PLL;
        ST_RESET_PLL: if (timer == CNT_W'(ARST_CYCLES - 1)) state_next = ST_WAIT_LOCK;
        ST_WAIT_LOCK, ST_STABILIZE: begin
          if (timeout) begin
            retry_next = retry + 1'b1;
            state_next = (retry_next == RETRY_W'(MAX_RETRIES)) ? ST_FAULT : ST_RESET_PLL;
          end else if (state == ST_WAIT_LOCK) begin
            if (lock_s) state_next = ST_STABILIZE;
          end else if (!lock_s) begin
            state_next = ST_WAIT_LOCK;
          end else if (timer == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
            state_next = ST_RUN;
            retry_next = '0;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_next = ST_RESET_PLL;
            relock_evt = 1'b1;
          end
        end
        ST_FAULT:     state_next = ST_FAULT;
        default:      state_next = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    // NOTE: non-blocking assignments, so every register here sees the pre-edge values of the others.
    if (!PRESET_N) begin
      state           <= ST_OFF;
      sync_ff         <= 1'b0;
      lock_s          <= 1'b0;
      timer           <= '0;
      to_cnt          <= '0;
      retry           <= '0;
      PLL_POWERDOWN_N <= 1'b0;
      PLL_ARST_N      <= 1'b0;
      FABRIC_RESET_N  <= 1'b0;
      LOCKED          <= 1'b0;
      FAULT           <= 1'b0;
      RELOCK_COUNT    <= '0;
    end else begin
      state   <= state_next;
      sync_ff <= LOCK;
      lock_s  <= sync_ff;
      timer   <= (state_next == state && (state == ST_RESET_PLL || state == ST_STABILIZE))
                 ? timer + 1'b1 : '0;
      to_cnt  <= (in_window && next_in_window) ? to_cnt + 1'b1 : '0;
      retry   <= retry_next;

      // Outputs are decoded from the next state so they change on the same edge as STATE.
      PLL_POWERDOWN_N <= (state_next != ST_OFF) && (state_next != ST_FAULT);
      PLL_ARST_N      <= next_in_window || (state_next == ST_RUN);
      FABRIC_RESET_N  <= (state_next == ST_RUN);
      LOCKED          <= (state_next == ST_RUN);
      if (state_next == ST_FAULT) FAULT <= 1'b1;
      if (relock_evt && RELOCK_COUNT != 8'hFF) RELOCK_COUNT <= RELOCK_COUNT + 8'd1;
    end
  end

  assign STATE = state;

endmodule

// File: doc/ccc_lock_supervisor.md
# ccc_lock_supervisor

Sequences and supervises one fabric CCC (PLL) instance: it drives the PLL's power-down and asynchronous-reset pins, qualifies the raw LOCK output, and releases a fabric reset only after lock has been stable for a programmed interval. It sits beside the CCC wrapper and runs on a free-running clock (RC oscillator or MSS clock), never on the CCC's own GL output. On lock loss it re-arms the PLL and counts the event. After repeated lock timeouts it latches a fault.

## Interface
- ARST_CYCLES, 16: PLL_ARST_N low pulse width, in PCLK cycles (≥1).
- LOCK_STABLE_CYCLES, 1024: number of consecutive synchronized-LOCK-high cycles required before release (≥1).
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed from PLL_ARST_N release to reaching RUN.
- MAX_RETRIES, 3: consecutive lock timeouts before entering FAULT (≥1).
- CNT_W, 17: timer width; must hold max(ARST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES).

- PCLK  in  1  free-running supervisor clock; single clock domain.
- PRESET_N  in  1  synchronous, active-low reset.
- LOCK  in  1  raw CCC lock, asynchronous to PCLK.
- ENABLE  in  1  level; high = PLL requested on.
- PLL_POWERDOWN_N  out  1  to CCC PLL_POWERDOWN_N.
- PLL_ARST_N  out  1  to CCC PLL_ARST_N.
- FABRIC_RESET_N  out  1  downstream reset release; downstream resynchronizes it.
- LOCKED  out  1  qualified lock.
- FAULT  out  1  sticky timeout fault.
- RELOCK_COUNT  out  8  saturating count of lock losses seen in RUN.
- STATE  out  3  debug state code.

## Operation
- LOCK passes through a 2-flop synchronizer to produce lock_s. All decisions use lock_s.
- State codes: OFF=0, RESET_PLL=1, WAIT_LOCK=2, STABILIZE=3, RUN=4, FAULT_ST=5. All outputs are registered and update on the same edge as the state transition.
- OFF: POWERDOWN_N=0, ARST_N=0, FABRIC_RESET_N=0, LOCKED=0. The retry counter clears. If ENABLE=1 → RESET_PLL.
- RESET_PLL: POWERDOWN_N=1, ARST_N=0. The timer runs ARST_CYCLES cycles, then → WAIT_LOCK. The timer and timeout counter clear on entry.
- WAIT_LOCK: ARST_N=1.
  - lock_s=1 → STABILIZE.
  - Timeout counter reaching LOCK_TIMEOUT_CYCLES → retry+1. If the new retry equals MAX_RETRIES → FAULT_ST, otherwise → RESET_PLL.
- STABILIZE: the stable timer counts cycles with lock_s=1.
  - lock_s=0 → WAIT_LOCK. The stable timer clears. The timeout counter keeps running, so chatter still times out.
  - Timeout applies here exactly as in WAIT_LOCK and takes priority over stable completion on the same cycle.
  - Stable timer reaching LOCK_STABLE_CYCLES → RUN. FABRIC_RESET_N=1, LOCKED=1, retry clears.
- RUN: lock_s=0 → RESET_PLL. FABRIC_RESET_N=0, LOCKED=0, RELOCK_COUNT+1 (saturates at 255).
- FAULT_ST: POWERDOWN_N=0, ARST_N=0, FABRIC_RESET_N=0, LOCKED=0, FAULT=1. Exits only to OFF on ENABLE=0.
- ENABLE=0 in any state → OFF on the next edge. This overrides all transitions except PRESET_N.
- FAULT and RELOCK_COUNT clear only on PRESET_N.

## Timing
- Reset values (PRESET_N=0 at an edge): STATE=OFF, PLL_POWERDOWN_N=0, PLL_ARST_N=0, FABRIC_RESET_N=0, LOCKED=0, FAULT=0, RELOCK_COUNT=0. Synchronizer, timers and retry counter are all 0.
- Reset mid-operation behaves identically to power-up reset. The PLL is powered down immediately on that edge.
- ENABLE rises, sampled at edge e:
  - RESET_PLL at e.
  - PLL_ARST_N rises at e+ARST_CYCLES.
- LOCK rise, first sampled at edge k:
  - lock_s=1 after k+1.
  - STABILIZE at k+2.
  - RUN and FABRIC_RESET_N=1 at k+2+LOCK_STABLE_CYCLES.
- LOCK fall in RUN, first sampled at edge k: FABRIC_RESET_N=0, LOCKED=0 and RELOCK_COUNT update at k+2.
- LOCK pulses shorter than one PCLK period may be missed. This is acceptable.

## Test plan
- Parameters for all scenarios: ARST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, MAX_RETRIES=3.
- Nominal bring-up: reset, ENABLE=1, LOCK rises 10 cycles after ARST_N release → ARST_N low exactly 4 cycles; FABRIC_RESET_N=1 exactly 10 edges after LOCK first sampled; STATE=4; RELOCK_COUNT=0.
- Timeout fault: LOCK held 0 → three ARST_N pulses spaced 4+64 cycles; then FAULT=1, STATE=5, POWERDOWN_N=0. ENABLE=0 → STATE=0 while FAULT stays 1.
- Lock chatter in STABILIZE: LOCK high 5 cycles, low 1, high again → FABRIC_RESET_N held 0 until 8 consecutive lock_s cycles. If chatter persists, timeout and retry fire.
- Lock loss in RUN: drop LOCK for 20 cycles → FABRIC_RESET_N=0 two edges after sampling; RELOCK_COUNT=1; new ARST_N pulse; relock reaches RUN with retry reset.
- Saturation and override: force 300 lock losses → RELOCK_COUNT=255. ENABLE=0 during STABILIZE → OFF next edge with POWERDOWN_N=0. PRESET_N=0 in RUN → all outputs take their reset values on that edge.
